fault_campaign_sequencer: RTL

//   Sequences a fault-injection campaign across NUM_GATES fault gates that share one controller.
//   Per gate:
//     - drive that gate's fault_in for DWELL_CYCLES;
//     - count the cycles its out is high;
//     - pulse the shared logic_reset for RECOVER_CYCLES;
//     - hand the result to the host over a valid/ready channel.

---
 rtl/fault_campaign_sequencer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fault_campaign_sequencer.sv
// fault_campaign_sequencer: dwells a fault on each gate in turn, counts its high cycles, pulses logic_reset, reports.
// Outputs are registered from the next state; define FAULT_SEQ_LOOP_EN to restart the campaign after DONE.
module fault_campaign_sequencer #(
  parameter int NUM_GATES      = 4,
  parameter int DWELL_CYCLES   = 64,
  parameter int RECOVER_CYCLES = 4,
  localparam int IDX_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1,
  localparam int CNT_W = $clog2(DWELL_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM_GATES-1:0] gate_out,
  output logic [NUM_GATES-1:0] fault_en,
  output logic                 logic_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDX_W-1:0]     res_idx,
  output logic [CNT_W-1:0]     res_count
);

  localparam int REC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_GATES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HIT_MAX    = CNT_W'(DWELL_CYCLES);
  localparam logic [REC_W-1:0] REC_LAST   = REC_W'(RECOVER_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_INJECT, S_RECOVER, S_REPORT, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] dwell_cnt, dwell_nxt;
  logic [CNT_W-1:0] hit, hit_nxt;
  logic [REC_W-1:0] rec_cnt, rec_nxt;
  logic             abort_lat, abort_nxt;

  logic [NUM_GATES-1:0] fault_en_nxt;
  logic                 logic_reset_nxt, busy_nxt, done_nxt, res_valid_nxt;
  logic [IDX_W-1:0]     res_idx_nxt;
  logic [CNT_W-1:0]     res_count_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      dwell_cnt   <= '0;
      hit         <= '0;
      rec_cnt     <= '0;
      abort_lat   <= 1'b0;
      fault_en    <= '0;
      logic_reset <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      res_valid   <= 1'b0;
      res_idx     <= '0;
      res_count   <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      dwell_cnt   <= dwell_nxt;
      hit         <= hit_nxt;
      rec_cnt     <= rec_nxt;
      abort_lat   <= abort_nxt;
      fault_en    <= fault_en_nxt;
      logic_reset <= logic_reset_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      res_valid   <= res_valid_nxt;
      res_idx     <= res_idx_nxt;
      res_count   <= res_count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    dwell_nxt = dwell_cnt;
    hit_nxt   = hit;
    rec_nxt   = rec_cnt;
    abort_nxt = abort_lat;
    unique case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nxt = S_INJECT;
          idx_nxt   = '0;
          dwell_nxt = '0;
          hit_nxt   = '0;
          abort_nxt = 1'b0;
        end
      end
      S_INJECT: begin
        dwell_nxt = dwell_cnt + 1'b1;
        if (gate_out[idx] && hit != HIT_MAX) hit_nxt = hit + 1'b1;
        // An abort still gets the full recovery pulse before returning to idle.
        if (abort || dwell_cnt == DWELL_LAST) begin
          state_nxt = S_RECOVER;
          rec_nxt   = '0;
          abort_nxt = abort_lat | abort;
        end
      end
      S_RECOVER: begin
        rec_nxt   = rec_cnt + 1'b1;
        abort_nxt = abort_lat | abort;
        if (rec_cnt == REC_LAST) state_nxt = (abort_lat || abort) ? S_IDLE : S_REPORT;
      end
      S_REPORT: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (res_ready) begin
          if (idx == IDX_LAST) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_INJECT;
            idx_nxt   = idx + 1'b1;
            dwell_nxt = '0;
            hit_nxt   = '0;
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
`ifdef FAULT_SEQ_LOOP_EN
          state_nxt = S_INJECT;
          idx_nxt   = '0;
          dwell_nxt = '0;
          hit_nxt   = '0;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fault_en_nxt    = '0;
    logic_reset_nxt = 1'b0;
    busy_nxt        = (state_nxt != S_IDLE);
    done_nxt        = 1'b0;
    res_valid_nxt   = 1'b0;
    res_idx_nxt     = '0;
    res_count_nxt   = '0;
    case (state_nxt)
      S_INJECT:  fault_en_nxt = NUM_GATES'(1) << idx_nxt;
      S_RECOVER: logic_reset_nxt = 1'b1;
      S_REPORT: begin
        res_valid_nxt = 1'b1;
        res_idx_nxt   = idx_nxt;
        res_count_nxt = hit_nxt;
      end
      S_DONE:    done_nxt = 1'b1;
      default:   ;
    endcase
  end

endmodule
